// File: rtl/pipe_fwd_chain_if.sv
// Signal bundle for pipe_fwd_chain: entry, late-result update, decode lookup,
// retire port and performance counters. clk/reset stay outside the bundle.
interface pipe_fwd_chain_if #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int RAW    = 5
);
  logic                     in_valid;
  logic                     in_we;
  logic [RAW-1:0]           in_rd;
  logic                     in_rdy;
  logic [XLEN-1:0]          in_data;
  logic                     flush_e;
  logic [STAGES-1:0]        upd_en;
  logic [STAGES*XLEN-1:0]   upd_data;
  logic [RAW-1:0]           lk_rs1;
  logic [RAW-1:0]           lk_rs2;
  logic                     lk1_hit;
  logic                     lk2_hit;
  logic [XLEN-1:0]          lk1_data;
  logic [XLEN-1:0]          lk2_data;
  logic                     stall_req;
  logic [STAGES-1:0]        stage_valid;
  logic                     ret_valid;
  logic                     ret_we;
  logic [RAW-1:0]           ret_rd;
  logic [XLEN-1:0]          ret_data;
  logic [31:0]              perf_retired;
  logic [31:0]              perf_stalls;

  modport master (
    output in_valid, in_we, in_rd, in_rdy, in_data, flush_e,
           upd_en, upd_data, lk_rs1, lk_rs2,
    input  lk1_hit, lk2_hit, lk1_data, lk2_data, stall_req, stage_valid,
           ret_valid, ret_we, ret_rd, ret_data, perf_retired, perf_stalls
  );

  modport slave (
    input  in_valid, in_we, in_rd, in_rdy, in_data, flush_e,
           upd_en, upd_data, lk_rs1, lk_rs2,
    output lk1_hit, lk2_hit, lk1_data, lk2_data, stall_req, stage_valid,
           ret_valid, ret_we, ret_rd, ret_data, perf_retired, perf_stalls
  );
endinterface

// File: rtl/pipe_fwd_chain.sv
// EX..WB destination/result chain with youngest-match forwarding, load-use stall
// request and register-file retire port. Counters built only with PIPE_FWD_PERF_EN.
module pipe_fwd_chain #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int RAW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  pipe_fwd_chain_if.slave bus
);
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] we_q, we_d;
  logic [STAGES-1:0] rdy_q, rdy_d;
  logic [RAW-1:0]    rd_q   [STAGES];
  logic [RAW-1:0]    rd_d   [STAGES];
  logic [XLEN-1:0]   data_q [STAGES];
  logic [XLEN-1:0]   data_d [STAGES];

  logic [STAGES-1:0] eff_rdy;
  logic [XLEN-1:0]   eff_data [STAGES];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    assign eff_rdy[gi]  = rdy_q[gi] | bus.upd_en[gi];
    assign eff_data[gi] = bus.upd_en[gi] ? bus.upd_data[gi*XLEN +: XLEN] : data_q[gi];
    if (gi == 0) begin : g_head
      assign v_d[gi]    = bus.in_valid & ~bus.flush_e;
      assign we_d[gi]   = bus.in_we;
      assign rdy_d[gi]  = bus.in_rdy;
      assign rd_d[gi]   = bus.in_rd;
      assign data_d[gi] = bus.in_data;
    end else begin : g_body
      // Late results captured this cycle travel on with the instruction.
      assign v_d[gi]    = v_q[gi-1];
      assign we_d[gi]   = we_q[gi-1];
      assign rdy_d[gi]  = eff_rdy[gi-1];
      assign rd_d[gi]   = rd_q[gi-1];
      assign data_d[gi] = eff_data[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      we_q  <= '0;
      rdy_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      we_q  <= we_d;
      rdy_q <= rdy_d;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k]   <= rd_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  logic            m1_found, m1_rdy, m2_found, m2_rdy;
  logic [XLEN-1:0] m1_data, m2_data;

  // Scan oldest to youngest so the lowest matching stage is the one left standing.
  always_comb begin
    m1_found = 1'b0;
    m1_rdy   = 1'b0;
    m1_data  = '0;
    m2_found = 1'b0;
    m2_rdy   = 1'b0;
    m2_data  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (v_q[k] && we_q[k] && (rd_q[k] == bus.lk_rs1) && (bus.lk_rs1 != '0)) begin
        m1_found = 1'b1;
        m1_rdy   = eff_rdy[k];
        m1_data  = eff_data[k];
      end
      if (v_q[k] && we_q[k] && (rd_q[k] == bus.lk_rs2) && (bus.lk_rs2 != '0)) begin
        m2_found = 1'b1;
        m2_rdy   = eff_rdy[k];
        m2_data  = eff_data[k];
      end
    end
  end

  logic stall;
  logic ret_valid;

  assign stall         = (m1_found & ~m1_rdy) | (m2_found & ~m2_rdy);
  assign ret_valid     = v_q[STAGES-1];
  assign bus.lk1_hit   = m1_found & m1_rdy;
  assign bus.lk2_hit   = m2_found & m2_rdy;
  assign bus.lk1_data  = (m1_found & m1_rdy) ? m1_data : '0;
  assign bus.lk2_data  = (m2_found & m2_rdy) ? m2_data : '0;
  assign bus.stall_req = stall;

  assign bus.stage_valid = v_q;
  assign bus.ret_valid   = ret_valid;
  assign bus.ret_we      = we_q[STAGES-1] & ret_valid;
  assign bus.ret_rd      = rd_q[STAGES-1];
  assign bus.ret_data    = eff_data[STAGES-1];

`ifdef PIPE_FWD_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stalls_q, stalls_d;

  assign retired_d = retired_q + {31'd0, ret_valid};
  assign stalls_d  = stalls_q + {31'd0, stall};

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      stalls_q  <= '0;
    end else begin
      retired_q <= retired_d;
      stalls_q  <= stalls_d;
    end
  end

  assign bus.perf_retired = retired_q;
  assign bus.perf_stalls  = stalls_q;
`else
  assign bus.perf_retired = '0;
  assign bus.perf_stalls  = '0;
`endif

`ifndef SYNTHESIS
  // A writing instruction must have its result by the time it reaches the regfile port.
  wb_result_known: assert property (@(posedge clk) disable iff (reset)
    !(v_q[STAGES-1] && we_q[STAGES-1] && !eff_rdy[STAGES-1]));
`endif
endmodule

// File: tb/tb_pipe_fwd_chain.sv
// Bench for pipe_fwd_chain: directed scenarios then randomized traffic, checked
// against an issue-time instruction log. Counter expectations follow PIPE_FWD_PERF_EN.
module tb_pipe_fwd_chain;
  localparam int XLEN = 32;
  localparam int S    = 3;
  localparam int RAW  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_fwd_chain_if #(.XLEN(XLEN), .STAGES(S), .RAW(RAW)) bus ();
  pipe_fwd_chain #(.XLEN(XLEN), .STAGES(S), .RAW(RAW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One record per captured instruction; its stage is the number of edges since capture.
  typedef struct {
    int             e;
    bit             we;
    logic [RAW-1:0] rd;
    int             vis;
    logic [XLEN-1:0] val;
    int             plan;
  } ent_t;

  ent_t        mq[$];
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          pending_plan;
  logic [31:0] m_retired;
  logic [31:0] m_stalls;
  bit          exp_ret_v;
  bit          exp_stall;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic int find_stage(int k);
    for (int i = 0; i < mq.size(); i++)
      if (cyc - mq[i].e == k) return i;
    return -1;
  endfunction

  task automatic model_upd();
    for (int k = 0; k < S; k++) begin
      if (bus.upd_en[k]) begin
        int idx;
        ent_t t;
        idx = find_stage(k);
        if (idx >= 0) begin
          t = mq[idx];
          if (k < t.vis) t.vis = k;
          t.val = bus.upd_data[k*XLEN +: XLEN];
          mq[idx] = t;
        end
      end
    end
  endtask

  task automatic model_lookup(input logic [RAW-1:0] rs, output bit hit, output bit stall,
                              output logic [XLEN-1:0] data, output bit dchk);
    int best;
    best  = -1;
    hit   = 1'b0;
    stall = 1'b0;
    data  = '0;
    dchk  = 1'b1;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].we && mq[i].rd == rs && rs != 0 && (best < 0 || mq[i].e > mq[best].e))
        best = i;
    if (best >= 0) begin
      if (cyc - mq[best].e >= mq[best].vis) begin
        hit  = 1'b1;
        data = mq[best].val;
      end else begin
        stall = 1'b1;
        dchk  = 1'b0;
      end
    end
  endtask

  task automatic check_perf();
`ifdef PIPE_FWD_PERF_EN
    check_eq("perf_retired", bus.perf_retired, m_retired);
    check_eq("perf_stalls", bus.perf_stalls, m_stalls);
`else
    check_eq("perf_retired", bus.perf_retired, 32'd0);
    check_eq("perf_stalls", bus.perf_stalls, 32'd0);
`endif
  endtask

  task automatic tick();
    bit h1, s1, d1, h2, s2, d2;
    logic [XLEN-1:0] x1, x2;
    logic [S-1:0] sv;
    int r;
    ent_t t;
    model_upd();
    #1;
    model_lookup(bus.lk_rs1, h1, s1, x1, d1);
    model_lookup(bus.lk_rs2, h2, s2, x2, d2);
    check_eq("lk1_hit", bus.lk1_hit, h1);
    if (d1) check_eq("lk1_data", bus.lk1_data, x1);
    check_eq("lk2_hit", bus.lk2_hit, h2);
    if (d2) check_eq("lk2_data", bus.lk2_data, x2);
    exp_stall = s1 | s2;
    check_eq("stall_req", bus.stall_req, exp_stall);
    sv = '0;
    foreach (mq[i]) sv[cyc - mq[i].e] = 1'b1;
    check_eq("stage_valid", bus.stage_valid, sv);
    r = find_stage(S - 1);
    exp_ret_v = (r >= 0);
    check_eq("ret_valid", bus.ret_valid, exp_ret_v);
    if (exp_ret_v) begin
      check_eq("ret_we", bus.ret_we, mq[r].we);
      check_eq("ret_rd", bus.ret_rd, mq[r].rd);
      check_eq("ret_data", bus.ret_data, mq[r].val);
    end else begin
      check_eq("ret_we", bus.ret_we, 1'b0);
    end
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_retired = '0;
      m_stalls  = '0;
    end else begin
      m_retired += exp_ret_v;
      m_stalls  += exp_stall;
      if (bus.in_valid && !bus.flush_e) begin
        t.e    = cyc + 1;
        t.we   = bus.in_we;
        t.rd   = bus.in_rd;
        t.vis  = bus.in_rdy ? 0 : S;
        t.val  = bus.in_rdy ? bus.in_data : '0;
        t.plan = bus.in_rdy ? -1 : pending_plan;
        mq.push_back(t);
      end
    end
    cyc++;
    while (mq.size() > 0 && cyc - mq[0].e >= S) void'(mq.pop_front());
    #1;
    check_perf();
  endtask

  task automatic idle();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_we    = 1'b0;
    bus.in_rd    = '0;
    bus.in_rdy   = 1'b0;
    bus.in_data  = '0;
    bus.flush_e  = 1'b0;
    bus.upd_en   = '0;
    bus.upd_data = '0;
    bus.lk_rs1   = '0;
    bus.lk_rs2   = '0;
    pending_plan = -1;
  endtask

  task automatic enter(input logic [RAW-1:0] rd, input bit we, input bit rdy, input logic [XLEN-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_we    = we;
    bus.in_rd    = rd;
    bus.in_rdy   = rdy;
    bus.in_data  = d;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    m_retired = '0;
    m_stalls  = '0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    #1;
    check_eq("rst_ret_valid", bus.ret_valid, 1'b0);
    check_eq("rst_ret_rd", bus.ret_rd, '0);
    check_eq("rst_ret_data", bus.ret_data, '0);
    check_eq("rst_stage_valid", bus.stage_valid, '0);
    check_eq("rst_stall", bus.stall_req, 1'b0);
    check_eq("rst_lk1_data", bus.lk1_data, '0);
    check_perf();
    tick();

    // Forward from every stage, then retire
    enter(5, 1'b1, 1'b1, 32'h11);
    tick();
    idle();
    bus.lk_rs1 = 5;
    for (int i = 0; i < S; i++) begin
      #1;
      check_eq("fwd_hit", bus.lk1_hit, 1'b1);
      check_eq("fwd_data", bus.lk1_data, 32'h11);
      if (i == S - 1) begin
        check_eq("fwd_ret_rd", bus.ret_rd, 5);
        check_eq("fwd_ret_data", bus.ret_data, 32'h11);
      end
      tick();
    end
`ifdef PIPE_FWD_PERF_EN
    check_eq("fwd_retired", bus.perf_retired, 32'd1);
`endif

    // Load-use: stall, then result arrives in stage 1
    enter(7, 1'b1, 1'b0, 32'hDEAD);
    tick();
    idle();
    bus.lk_rs2 = 7;
    #1;
    check_eq("lu_stall", bus.stall_req, 1'b1);
    check_eq("lu_hit0", bus.lk2_hit, 1'b0);
    tick();
    bus.upd_en = 3'b010;
    bus.upd_data[XLEN +: XLEN] = 32'h0000ABCD;
    #1;
    check_eq("lu_hit1", bus.lk2_hit, 1'b1);
    check_eq("lu_data1", bus.lk2_data, 32'h0000ABCD);
    check_eq("lu_stall1", bus.stall_req, 1'b0);
    tick();
    bus.upd_en = '0;
    #1;
    check_eq("lu_ret_data", bus.ret_data, 32'h0000ABCD);
    tick();

    // Youngest match wins
    idle();
    enter(3, 1'b1, 1'b1, 32'd1);
    tick();
    enter(3, 1'b1, 1'b1, 32'd2);
    tick();
    idle();
    bus.lk_rs1 = 3;
    #1;
    check_eq("young_data0", bus.lk1_data, 32'd2);
    tick();
    #1;
    check_eq("young_data1", bus.lk1_data, 32'd2);
    tick();

    // x0 never forwards; flushed entry never occupies a stage
    idle();
    enter(0, 1'b1, 1'b1, 32'h55);
    tick();
    idle();
    #1;
    check_eq("x0_hit", bus.lk1_hit, 1'b0);
    tick();
    enter(9, 1'b1, 1'b1, 32'h99);
    bus.flush_e = 1'b1;
    tick();
    idle();
    bus.lk_rs1 = 9;
    #1;
    check_eq("flush_v0", bus.stage_valid[0], 1'b0);
    check_eq("flush_hit", bus.lk1_hit, 1'b0);
    repeat (S) tick();

    // Reset with all stages full
    for (int i = 0; i < S; i++) begin
      enter(RAW'(i + 1), 1'b1, 1'b1, 32'h100 + i);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("mrst_stage_valid", bus.stage_valid, '0);
    check_eq("mrst_ret_valid", bus.ret_valid, 1'b0);
    check_eq("mrst_perf_retired", bus.perf_retired, 32'd0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit h, s, dc, st;
      logic [XLEN-1:0] d;
      reset      = ($urandom_range(63, 0) == 0);
      bus.lk_rs1 = RAW'($urandom_range(7, 0));
      bus.lk_rs2 = RAW'($urandom_range(7, 0));
      bus.upd_en = '0;
      bus.upd_data = {$urandom, $urandom, $urandom};
      for (int k = 0; k < S; k++) begin
        int idx;
        idx = find_stage(k);
        if (idx >= 0) begin
          if (mq[idx].plan == k || (mq[idx].vis <= k && $urandom_range(7, 0) == 0))
            bus.upd_en[k] = 1'b1;
        end else if ($urandom_range(3, 0) == 0) begin
          bus.upd_en[k] = 1'b1;
        end
      end
      model_upd();
      model_lookup(bus.lk_rs1, h, s, d, dc);
      st = s;
      model_lookup(bus.lk_rs2, h, s, d, dc);
      st = st | s;
      bus.in_valid = ($urandom_range(3, 0) != 0) && !st;
      bus.flush_e  = ($urandom_range(7, 0) == 0);
      bus.in_we    = ($urandom_range(3, 0) != 0);
      bus.in_rd    = RAW'($urandom_range(7, 0));
      bus.in_rdy   = $urandom_range(1, 0) != 0;
      bus.in_data  = $urandom;
      pending_plan = $urandom_range(S - 1, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
